tile_text_renderer: RTL and testbench
=====================================

# tile_text_renderer

Character-cell text renderer directly downstream of the sync/counter generator. It consumes the generator's 9-bit horizontal/vertical counters, display-area flag and active-low syncs. It fetches tile codes from a 32x30 tile RAM and glyph rows from an 8x8 font ROM through a pipelined fetch, then shifts out a 4-bit colour index per pixel. Sync and display signals are re-timed by the same fixed latency so that downstream video output stays aligned.

## Interface
- LAT, 9: fixed input-to-output latency in clocks; not overridable, exposed for benches.
- clk  in  1  pixel clock, same clock as the sync generator.
- reset_n  in  1  asynchronous, active-low reset.
- hpos  in  9  horizontal counter, 0..299, wraps.
- vpos  in  9  vertical counter, 0..261; increments when hpos wraps.
- display_on  in  1  generator display-area flag.
- hsync_in, vsync_in  in  1 each  active-low syncs from generator.
- ram_en  out  1  tile RAM read strobe.
- ram_addr  out  10  tile RAM address {row[4:0], col[4:0]}.
- ram_data  in  16  tile word: [7:0] char code, [11:8] fg index, [15:12] bg index; synchronous read, valid 1 clock after address.
- rom_addr  out  11  font ROM address {char[7:0], glyph row[2:0]}.
- rom_data  in  8  glyph row, bit 7 = leftmost pixel; synchronous read, 1-clock latency.
- rgb  out  4  pixel colour index.
- hsync_out, vsync_out  out  1 each  hsync_in/vsync_in delayed LAT clocks.
- display_out  out  1  display_on delayed LAT clocks.

## Operation
- Cell k covers hpos 8k..8k+7; the row is vpos[7:3], the glyph row is vpos[2:0].
- Fetch cycle t0 is any clock with hpos[2:0]==0:
  - At the end of t0, register ram_addr={vpos[7:3],hpos[7:3]}. Pulse ram_en for one clock only if hpos<256 and vpos<240; otherwise ram_en=0 and ram_addr holds.
  - At the end of t0+2, latch char/fg/bg and register rom_addr={char,vpos[2:0]}.
  - At the end of t0+4, load the staging register with rom_data, fg and bg.
  - At the end of the clock with hpos[2:0]==7, load the 8-bit shift register plus colour pair from staging. Otherwise the shift register shifts left by 1, filling 0.
  - rgb is registered: the shift MSB selects fg when 1 and bg when 0. rgb is forced to 0 when the delayed display flag (the value that becomes display_out) is 0.
- Staging is never overwritten before its load: the next write occurs at t0+12, after the load at t0+7.
- Cells 32..37 (hpos≥256) and rows ≥30 fetch nothing, and their output is blanked by the display gate.
- hsync/vsync/display pass through a LAT-deep delay line with no other logic.

## Timing
- The pixel for the input sample at clock t (hpos=8k+j) appears on rgb at clock t+9. This holds for all j, including across cell boundaries and hpos wrap 299→0.
- hsync_out, vsync_out and display_out equal their inputs from 9 clocks earlier, so they are cycle-aligned with rgb.
- Reset (asynchronous assert) sets:
  - rgb=0, display_out=0;
  - hsync_out=1, vsync_out=1, and every delay stage to inactive (sync stages 1, display stages 0);
  - ram_en=0, ram_addr=0, rom_addr=0;
  - shift, staging and attribute registers to 0.
- Reset mid-line: outputs are inactive immediately. After release, the first fetch occurs at the next hpos[2:0]==0. Until the 9-stage pipeline fills, display_out is 0, so rgb is 0; no partial glyph is emitted. The first correct cell may begin mid-line.
- Counter jumps (hpos not incrementing) are not detected; alignment requires a free-running generator.

## Structure
- Shared package: CELL_W=8, COLS=32, ROWS=30, H_ACTIVE=256, V_ACTIVE=240, LAT=9, and the tile word field positions (CHAR, FG, BG).
- One sub-module: sync_delay_line, parameterised by depth and width with per-bit reset values. It carries {hsync, vsync, display} and is used here with depth 9.

## Test plan
- Reset hold: assert reset_n=0 mid-frame → rgb=0, hsync_out=vsync_out=1, display_out=0, ram_en=0 within the same clock; after release, display_out stays 0 for 9 clocks.
- Single glyph: tile (row 0, col 0)=0x3_5_41, font 'A' row 0=0x18, at hpos 0 vpos 0 → rgb at clocks 9..16 = 3,3,3,5,5,3,3,3.
- Address sequencing: vpos=13, hpos=40 → ram_addr=0x025 with ram_en pulse; char 0x7F → rom_addr=0x3FD two clocks later.
- Line wrap: tile col 31 glyph 0xFF and col 0 glyph 0x81 on consecutive lines → 8 fg pixels for hpos 248..255, blank (0) for hpos 256..299, then the next line's col 0 pattern with no slip.
- Sync alignment: compare hsync_out/vsync_out/display_out against hsync_in/vsync_in/display_on delayed 9 clocks over one full frame → zero mismatches.
- Blanking: vpos 240..261 → ram_en never asserted, rgb=0 throughout.

Source files
------------

// File: rtl/tile_text_renderer_pkg.sv
// Shared geometry, latency and tile-word layout for the character-cell text renderer.
// Also holds the fetch-phase encodings used by the pipelined tile/glyph fetch.
package tile_text_renderer_pkg;

    localparam int unsigned CELL_W   = 8;
    localparam int unsigned COLS     = 32;
    localparam int unsigned ROWS     = 30;
    localparam int unsigned H_ACTIVE = 256;
    localparam int unsigned V_ACTIVE = 240;
    localparam int unsigned LAT      = 9;

    // Tile word field positions.
    localparam int unsigned CHAR_LSB = 0;
    localparam int unsigned FG_LSB   = 8;
    localparam int unsigned BG_LSB   = 12;

    // hpos[2:0] values at which each fetch step fires.
    localparam logic [2:0] PH_ADDR  = 3'd0;
    localparam logic [2:0] PH_ATTR  = 3'd2;
    localparam logic [2:0] PH_STAGE = 3'd4;
    localparam logic [2:0] PH_LOAD  = 3'd7;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] chr;
    } tile_word_t;

    typedef struct packed {
        logic [7:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
    } cell_t;

    function automatic logic fetch_active(logic [8:0] h, logic [8:0] v);
        return (h < 9'(H_ACTIVE)) && (v < 9'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/tile_text_renderer_if.sv
// Video timing, tile RAM / font ROM and pixel output bundle of the text renderer.
// master = renderer side, slave = sync generator, memories and video sink.
interface tile_text_renderer_if;

    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        ram_en;
    logic [9:0]  ram_addr;
    logic [15:0] ram_data;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        display_out;

    modport master (
        input  hpos, vpos, display_on, hsync_in, vsync_in, ram_data, rom_data,
        output ram_en, ram_addr, rom_addr, rgb, hsync_out, vsync_out, display_out
    );

    modport slave (
        output hpos, vpos, display_on, hsync_in, vsync_in, ram_data, rom_data,
        input  ram_en, ram_addr, rom_addr, rgb, hsync_out, vsync_out, display_out
    );

endinterface

// File: rtl/tile_text_renderer_sync_delay_line.sv
// Fixed-depth shift-register delay line with a per-bit reset pattern.
// tap_o exposes one lane one stage early, i.e. the value the output takes next clock.
module tile_text_renderer_sync_delay_line #(
    parameter int unsigned     Depth    = 9,
    parameter int unsigned     Width    = 3,
    parameter logic [Width-1:0] ResetVal = '0,
    parameter int unsigned     TapBit   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             tap_o
);

    logic [Depth-1:0][Width-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = {stage_q[Depth-2:0], data_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= {Depth{ResetVal}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[Depth-1];
    assign tap_o  = stage_q[Depth-2][TapBit];

endmodule

// File: rtl/tile_text_renderer.sv
// Character-cell renderer: per 8-pixel cell fetches a tile word then a glyph row,
// stages them and shifts out 4-bit colour indices with syncs re-timed to match.
module tile_text_renderer
    import tile_text_renderer_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    tile_text_renderer_if.master bus
);

    logic [2:0] phase;
    logic       fetch_en;
    tile_word_t tile;

    assign phase    = bus.hpos[2:0];
    assign fetch_en = (phase == PH_ADDR) && fetch_active(bus.hpos, bus.vpos);
    assign tile     = tile_word_t'(bus.ram_data);

    logic        ram_en_q, ram_en_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [10:0] rom_addr_q, rom_addr_d;
    logic [3:0]  attr_fg_q, attr_fg_d;
    logic [3:0]  attr_bg_q, attr_bg_d;
    cell_t       staging_q, staging_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  fg_q, fg_d;
    logic [3:0]  bg_q, bg_d;
    logic [3:0]  rgb_q, rgb_d;

    logic [2:0]  sync_out;
    logic        disp_next;

    always_comb begin
        ram_en_d   = fetch_en;
        ram_addr_d = fetch_en ? {bus.vpos[7:3], bus.hpos[7:3]} : ram_addr_q;

        rom_addr_d = rom_addr_q;
        attr_fg_d  = attr_fg_q;
        attr_bg_d  = attr_bg_q;
        if (phase == PH_ATTR) begin
            rom_addr_d = {tile.chr, bus.vpos[2:0]};
            attr_fg_d  = tile.fg;
            attr_bg_d  = tile.bg;
        end

        staging_d = staging_q;
        if (phase == PH_STAGE) begin
            staging_d = '{glyph: bus.rom_data, fg: attr_fg_q, bg: attr_bg_q};
        end

        shift_d = {shift_q[6:0], 1'b0};
        fg_d    = fg_q;
        bg_d    = bg_q;
        if (phase == PH_LOAD) begin
            shift_d = staging_q.glyph;
            fg_d    = staging_q.fg;
            bg_d    = staging_q.bg;
        end

        // Gate with the display bit that lands on display_out alongside this pixel.
        rgb_d = disp_next ? (shift_q[7] ? fg_q : bg_q) : 4'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
            rom_addr_q <= '0;
            attr_fg_q  <= '0;
            attr_bg_q  <= '0;
            staging_q  <= '0;
            shift_q    <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            rgb_q      <= '0;
        end else begin
            ram_en_q   <= ram_en_d;
            ram_addr_q <= ram_addr_d;
            rom_addr_q <= rom_addr_d;
            attr_fg_q  <= attr_fg_d;
            attr_bg_q  <= attr_bg_d;
            staging_q  <= staging_d;
            shift_q    <= shift_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            rgb_q      <= rgb_d;
        end
    end

    tile_text_renderer_sync_delay_line #(
        .Depth    (LAT),
        .Width    (3),
        .ResetVal (3'b110),
        .TapBit   (0)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .data_i  ({bus.hsync_in, bus.vsync_in, bus.display_on}),
        .data_o  (sync_out),
        .tap_o   (disp_next)
    );

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.rgb         = rgb_q;
    assign bus.hsync_out   = sync_out[2];
    assign bus.vsync_out   = sync_out[1];
    assign bus.display_out = sync_out[0];

endmodule

// File: tb/tb_tile_text_renderer.sv
// Bench for tile_text_renderer: free-running timing generator, random tile/font
// contents and a per-pixel reference model compared LAT clocks later.
module tb_tile_text_renderer;
    import tile_text_renderer_pkg::*;

    typedef struct {
        int         h;
        int         v;
        logic       chk_rgb;
        logic [3:0] rgb;
        logic       hs;
        logic       vs;
        logic       disp;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tile_text_renderer_if bus ();

    tile_text_renderer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] tile_ram [1024];
    logic [7:0]  font_rom [2048];
    logic [3:0]  obs_rgb  [262][300];

    // Synchronous-read memories, one clock of latency.
    always @(posedge clk) begin
        if (!reset_n) begin
            bus.ram_data <= '0;
            bus.rom_data <= '0;
        end else begin
            if (bus.ram_en) bus.ram_data <= tile_ram[bus.ram_addr];
            bus.rom_data <= font_rom[bus.rom_addr];
        end
    end

    int   h, v;
    int   checks = 0;
    int   errors = 0;
    logic rgb_valid;
    exp_t q[$];

    function automatic logic [3:0] ref_pixel(int hh, int vv);
        logic [15:0] t;
        logic [7:0]  g;
        if (hh >= 256 || vv >= 240) return 4'h0;
        t = tile_ram[(vv / 8) * 32 + hh / 8];
        g = font_rom[int'(t[7:0]) * 8 + vv % 8];
        return g[7 - hh % 8] ? t[11:8] : t[15:12];
    endfunction

    task automatic drive();
        bus.hpos       = 9'(h);
        bus.vpos       = 9'(v);
        bus.display_on = (h < 256) && (v < 240);
        bus.hsync_in   = !(h >= 264 && h < 284);
        bus.vsync_in   = !(v >= 244 && v < 247);
    endtask

    task automatic advance();
        h++;
        if (h == 300) begin
            h = 0;
            v = (v == 261) ? 0 : v + 1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) tile_ram[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    endtask

    // One generator clock: record the sample's expected output, clock, score the oldest.
    task automatic step();
        exp_t e;
        logic exp_en;
        if (h % 8 == 0) rgb_valid = 1'b1;
        e.h = h;  e.v = v;
        e.chk_rgb = rgb_valid;
        e.rgb  = ref_pixel(h, v);
        e.hs   = bus.hsync_in;
        e.vs   = bus.vsync_in;
        e.disp = bus.display_on;
        exp_en = (h % 8 == 0) && (h < 256) && (v < 240);
        q.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (bus.ram_en !== exp_en) begin
            errors++;
            $display("FAIL ram_en h=%0d v=%0d got %b want %b", h, v, bus.ram_en, exp_en);
        end
        if (q.size() >= LAT) begin
            e = q.pop_front();
            if (e.chk_rgb) begin
                checks++;
                if (bus.rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL rgb h=%0d v=%0d got %h want %h", e.h, e.v, bus.rgb, e.rgb);
                end
            end
            checks += 3;
            if (bus.hsync_out !== e.hs) begin
                errors++;
                $display("FAIL hsync_out h=%0d v=%0d got %b want %b", e.h, e.v, bus.hsync_out, e.hs);
            end
            if (bus.vsync_out !== e.vs) begin
                errors++;
                $display("FAIL vsync_out h=%0d v=%0d got %b want %b", e.h, e.v, bus.vsync_out, e.vs);
            end
            if (bus.display_out !== e.disp) begin
                errors++;
                $display("FAIL display_out h=%0d v=%0d got %b want %b",
                         e.h, e.v, bus.display_out, e.disp);
            end
            if (e.h >= 0) obs_rgb[e.v][e.h] = bus.rgb;
        end
        advance();
        drive();
    endtask

    task automatic do_reset(int hold);
        reset_n = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            advance();
            drive();
        end
    endtask

    // Release mid-cycle; the delay line still shows its reset pattern for LAT-1 more edges.
    task automatic release_reset();
        exp_t e;
        reset_n   = 1'b1;
        rgb_valid = 1'b0;
        q.delete();
        e.h = -1;  e.v = -1;
        e.chk_rgb = 1'b1;  e.rgb = 4'h0;
        e.hs = 1'b1;  e.vs = 1'b1;  e.disp = 1'b0;
        repeat (LAT - 1) q.push_back(e);
    endtask

    task automatic test_reset();
        h = 100;  v = 50;
        drive();
        fill_random();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (bus.rgb !== 4'h0) begin
            errors++;  $display("FAIL por_rgb got %h want 0", bus.rgb);
        end
        if (bus.ram_en !== 1'b0 || bus.ram_addr !== 10'h0) begin
            errors++;  $display("FAIL por_ram got en=%b addr=%h want 0/0", bus.ram_en, bus.ram_addr);
        end
        if (bus.rom_addr !== 11'h0) begin
            errors++;  $display("FAIL por_rom_addr got %h want 0", bus.rom_addr);
        end
        if ({bus.hsync_out, bus.vsync_out, bus.display_out} !== 3'b110) begin
            errors++;
            $display("FAIL por_sync got %b%b%b want 110", bus.hsync_out, bus.vsync_out, bus.display_out);
        end
        release_reset();
        repeat (200 + $urandom_range(0, 50)) step();
        // Asynchronous assert between edges must clear outputs at once.
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (bus.rgb !== 4'h0) begin
            errors++;  $display("FAIL rst_rgb got %h want 0", bus.rgb);
        end
        if (bus.ram_en !== 1'b0 || bus.ram_addr !== 10'h0) begin
            errors++;  $display("FAIL rst_ram got en=%b addr=%h want 0/0", bus.ram_en, bus.ram_addr);
        end
        if (bus.rom_addr !== 11'h0) begin
            errors++;  $display("FAIL rst_rom_addr got %h want 0", bus.rom_addr);
        end
        if ({bus.hsync_out, bus.vsync_out, bus.display_out} !== 3'b110) begin
            errors++;
            $display("FAIL rst_sync got %b%b%b want 110", bus.hsync_out, bus.vsync_out, bus.display_out);
        end
        do_reset(3);
        release_reset();
        repeat (40) step();
    endtask

    task automatic test_single_glyph();
        logic [3:0] want [8] = '{4'h3, 4'h3, 4'h3, 4'h5, 4'h5, 4'h3, 4'h3, 4'h3};
        do_reset(2);
        tile_ram[0]       = 16'h3541;
        font_rom[8'h41 * 8] = 8'h18;
        for (int j = 0; j < 8; j++) obs_rgb[0][j] = 4'hx;
        h = 290;  v = 261;
        drive();
        release_reset();
        repeat (40) step();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (obs_rgb[0][j] !== want[j]) begin
                errors++;
                $display("FAIL glyph_A px%0d got %h want %h", j, obs_rgb[0][j], want[j]);
            end
        end
    endtask

    task automatic test_address();
        int n = 0;
        do_reset(2);
        tile_ram[37] = {8'($urandom), 8'h7F};
        h = 30;  v = 13;
        drive();
        release_reset();
        while (h != 40 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (h != 40) begin
            errors++;  $display("FAIL addr_wait got h=%0d want 40", h);
        end
        step();
        checks += 2;
        if (bus.ram_en !== 1'b1) begin
            errors++;  $display("FAIL addr_en_pulse got %b want 1", bus.ram_en);
        end
        if (bus.ram_addr !== 10'h025) begin
            errors++;  $display("FAIL addr_ram got %h want 025", bus.ram_addr);
        end
        step();
        checks++;
        if (bus.ram_en !== 1'b0) begin
            errors++;  $display("FAIL addr_en_one_clk got %b want 0", bus.ram_en);
        end
        step();
        checks++;
        if (bus.rom_addr !== 11'h3FD) begin
            errors++;  $display("FAIL addr_rom got %h want 3fd", bus.rom_addr);
        end
    endtask

    task automatic test_line_wrap();
        logic [3:0] want0 [8] = '{4'hC, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'hC};
        do_reset(2);
        tile_ram[2 * 32 + 31]  = 16'h2A10;
        font_rom[8'h10 * 8]    = 8'hFF;
        tile_ram[2 * 32 + 0]   = 16'h6C11;
        font_rom[8'h11 * 8 + 1] = 8'h81;
        for (int j = 248; j < 300; j++) obs_rgb[16][j] = 4'hx;
        for (int j = 0; j < 8; j++) obs_rgb[17][j] = 4'hx;
        h = 230;  v = 16;
        drive();
        release_reset();
        repeat (110) step();
        for (int j = 248; j < 256; j++) begin
            checks++;
            if (obs_rgb[16][j] !== 4'hA) begin
                errors++;  $display("FAIL wrap_col31 h=%0d got %h want a", j, obs_rgb[16][j]);
            end
        end
        for (int j = 256; j < 300; j++) begin
            checks++;
            if (obs_rgb[16][j] !== 4'h0) begin
                errors++;  $display("FAIL wrap_blank h=%0d got %h want 0", j, obs_rgb[16][j]);
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (obs_rgb[17][j] !== want0[j]) begin
                errors++;
                $display("FAIL wrap_col0 h=%0d got %h want %h", j, obs_rgb[17][j], want0[j]);
            end
        end
    endtask

    task automatic test_full_frame();
        do_reset(2);
        fill_random();
        h = $urandom_range(0, 299);
        v = $urandom_range(0, 261);
        drive();
        release_reset();
        repeat (300 * 262) step();
    endtask

    initial begin
        test_reset();
        test_single_glyph();
        test_address();
        test_line_wrap();
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
